// File: rtl/mispredict_recovery_ctrl.sv
// Branch-mispredict recovery sequencer: walks the ROB youngest-to-branch undoing renames, rewinds the tail, flips epoch, redirects fetch.
// Optional RECOVERY_PERF_CNT_EN adds saturating recovery and walk-cycle counters.
module mispredict_recovery_ctrl #(
  parameter int ROB_SIZE = 16,
  parameter int ROB_W    = $clog2(ROB_SIZE),
  parameter int PHYS_W   = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mp_valid,
  input  logic [ROB_W-1:0]  mp_rob_idx,
  input  logic              mp_epoch,
  input  logic [31:0]       mp_target_pc,
  input  logic [ROB_W-1:0]  rob_head,
  input  logic [ROB_W-1:0]  rob_tail,
  output logic [ROB_W-1:0]  walk_rd_idx,
  input  logic              walk_uses_rd,
  input  logic [4:0]        walk_rd_arch,
  input  logic [PHYS_W-1:0] walk_pd_old,
  input  logic [PHYS_W-1:0] walk_pd_new,
  output logic              rat_wr_valid,
  output logic [4:0]        rat_wr_arch,
  output logic [PHYS_W-1:0] rat_wr_phys,
  output logic              fl_push_valid,
  output logic [PHYS_W-1:0] fl_push_pd,
  output logic              rob_tail_wr_valid,
  output logic [ROB_W-1:0]  rob_tail_wr_idx,
  output logic              epoch,
  output logic              stall_alloc,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  input  logic              redirect_ready,
`ifdef RECOVERY_PERF_CNT_EN
  output logic [31:0]       perf_recoveries,
  output logic [31:0]       perf_walk_cycles,
`endif
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, WALK, FIXUP, REDIRECT} state_t;

  localparam logic [ROB_W-1:0] ONE = ROB_W'(1);

  state_t            state_q, state_d;
  logic [ROB_W-1:0]  stop_q, stop_d;
  logic [ROB_W-1:0]  cursor_q, cursor_d;
  logic [31:0]       pc_q, pc_d;
  logic              epoch_q, epoch_d;
  logic              report_ok;
  logic              report_older;
  logic [ROB_W-1:0]  mp_age, stop_age, eff_stop;

  // Ages are head-relative so the comparison survives index wrap-around.
  assign report_ok    = mp_valid && (mp_epoch == epoch_q);
  assign mp_age       = mp_rob_idx - rob_head;
  assign stop_age     = stop_q - rob_head;
  assign report_older = mp_age < stop_age;
  assign epoch        = epoch_q;
  assign busy         = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      stop_q   <= '0;
      cursor_q <= '0;
      pc_q     <= '0;
      epoch_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      stop_q   <= stop_d;
      cursor_q <= cursor_d;
      pc_q     <= pc_d;
      epoch_q  <= epoch_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    stop_d            = stop_q;
    cursor_d          = cursor_q;
    pc_d              = pc_q;
    epoch_d           = epoch_q;
    eff_stop          = stop_q;
    walk_rd_idx       = '0;
    rat_wr_valid      = 1'b0;
    rat_wr_arch       = '0;
    rat_wr_phys       = '0;
    fl_push_valid     = 1'b0;
    fl_push_pd        = '0;
    rob_tail_wr_valid = 1'b0;
    rob_tail_wr_idx   = '0;
    redirect_valid    = 1'b0;
    redirect_pc       = '0;
    stall_alloc       = busy;
    case (state_q)
      IDLE: begin
        if (report_ok) begin
          stop_d      = mp_rob_idx;
          pc_d        = mp_target_pc;
          cursor_d    = rob_tail - ONE;
          state_d     = WALK;
          stall_alloc = 1'b1;
        end
      end
      WALK: begin
        walk_rd_idx = cursor_q;
        // An older branch arriving now takes effect this cycle, so the entry under the cursor is undone too.
        if (report_ok && report_older) begin
          stop_d   = mp_rob_idx;
          pc_d     = mp_target_pc;
          eff_stop = mp_rob_idx;
        end
        if (cursor_q == eff_stop) begin
          state_d = FIXUP;
        end else begin
          cursor_d = cursor_q - ONE;
          if (walk_uses_rd) begin
            rat_wr_valid  = 1'b1;
            rat_wr_arch   = walk_rd_arch;
            rat_wr_phys   = walk_pd_old;
            fl_push_valid = 1'b1;
            fl_push_pd    = walk_pd_new;
          end
        end
      end
      FIXUP: begin
        rob_tail_wr_valid = 1'b1;
        rob_tail_wr_idx   = stop_q + ONE;
        epoch_d           = ~epoch_q;
        state_d           = REDIRECT;
      end
      REDIRECT: begin
        redirect_valid = 1'b1;
        redirect_pc    = pc_q;
        if (redirect_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef RECOVERY_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_recoveries  <= '0;
      perf_walk_cycles <= '0;
    end else begin
      if (state_q == FIXUP && perf_recoveries != '1)
        perf_recoveries <= perf_recoveries + 32'd1;
      if (state_q == WALK && perf_walk_cycles != '1)
        perf_walk_cycles <= perf_walk_cycles + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mispredict_recovery_ctrl.sv
// Directed bench for mispredict_recovery_ctrl: a small ROB model feeds the walk port and a scoreboard
// holds the expected RAT restores, freelist returns and tail rewinds.
module tb_mispredict_recovery_ctrl;

  logic        clk;
  logic        rst_n;
  logic        mp_valid;
  logic [3:0]  mp_rob_idx;
  logic        mp_epoch;
  logic [31:0] mp_target_pc;
  logic [3:0]  rob_head;
  logic [3:0]  rob_tail;
  logic [3:0]  walk_rd_idx;
  logic        walk_uses_rd;
  logic [4:0]  walk_rd_arch;
  logic [5:0]  walk_pd_old;
  logic [5:0]  walk_pd_new;
  logic        rat_wr_valid;
  logic [4:0]  rat_wr_arch;
  logic [5:0]  rat_wr_phys;
  logic        fl_push_valid;
  logic [5:0]  fl_push_pd;
  logic        rob_tail_wr_valid;
  logic [3:0]  rob_tail_wr_idx;
  logic        epoch;
  logic        stall_alloc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        redirect_ready;
  logic        busy;
`ifdef RECOVERY_PERF_CNT_EN
  logic [31:0] perf_recoveries;
  logic [31:0] perf_walk_cycles;
`endif

  logic        rob_uses [16];
  logic [4:0]  rob_arch [16];
  logic [5:0]  rob_old  [16];
  logic [5:0]  rob_new  [16];

  logic [10:0] rat_q [$];
  logic [5:0]  fl_q  [$];
  logic [3:0]  tail_q[$];

  int checks;
  int failures;
  int cyc;
  int accept_cyc;

  mispredict_recovery_ctrl dut (
    .clk(clk), .rst_n(rst_n),
    .mp_valid(mp_valid), .mp_rob_idx(mp_rob_idx), .mp_epoch(mp_epoch), .mp_target_pc(mp_target_pc),
    .rob_head(rob_head), .rob_tail(rob_tail),
    .walk_rd_idx(walk_rd_idx), .walk_uses_rd(walk_uses_rd), .walk_rd_arch(walk_rd_arch),
    .walk_pd_old(walk_pd_old), .walk_pd_new(walk_pd_new),
    .rat_wr_valid(rat_wr_valid), .rat_wr_arch(rat_wr_arch), .rat_wr_phys(rat_wr_phys),
    .fl_push_valid(fl_push_valid), .fl_push_pd(fl_push_pd),
    .rob_tail_wr_valid(rob_tail_wr_valid), .rob_tail_wr_idx(rob_tail_wr_idx),
    .epoch(epoch), .stall_alloc(stall_alloc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .redirect_ready(redirect_ready),
`ifdef RECOVERY_PERF_CNT_EN
    .perf_recoveries(perf_recoveries), .perf_walk_cycles(perf_walk_cycles),
`endif
    .busy(busy)
  );

  assign walk_uses_rd = rob_uses[walk_rd_idx];
  assign walk_rd_arch = rob_arch[walk_rd_idx];
  assign walk_pd_old  = rob_old[walk_rd_idx];
  assign walk_pd_new  = rob_new[walk_rd_idx];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every write strobe the DUT raises must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rat_wr_valid) begin
        if (rat_q.size() == 0) checkOutput("rat_unexpected", 32'(rat_wr_valid), 32'd0);
        else checkOutput("rat_write", 32'({rat_wr_arch, rat_wr_phys}), 32'(rat_q.pop_front()));
      end
      if (fl_push_valid) begin
        if (fl_q.size() == 0) checkOutput("fl_unexpected", 32'(fl_push_valid), 32'd0);
        else checkOutput("fl_push", 32'(fl_push_pd), 32'(fl_q.pop_front()));
      end
      if (rob_tail_wr_valid) begin
        if (tail_q.size() == 0) checkOutput("tail_unexpected", 32'(rob_tail_wr_valid), 32'd0);
        else checkOutput("tail_wr_idx", 32'(rob_tail_wr_idx), 32'(tail_q.pop_front()));
      end
    end
  end

  task automatic clearRob();
    for (int i = 0; i < 16; i++) begin
      rob_uses[i] = 1'b0; rob_arch[i] = '0; rob_old[i] = '0; rob_new[i] = '0;
    end
  endtask

  task automatic setEntry(input int i, input logic [4:0] a, input logic [5:0] pn, input logic [5:0] po);
    rob_uses[i] = 1'b1; rob_arch[i] = a; rob_new[i] = pn; rob_old[i] = po;
  endtask

  task automatic loadRobLong();
    clearRob();
    setEntry(5, 5'd7, 6'd45, 6'd15);
    setEntry(4, 5'd8, 6'd44, 6'd14);
    setEntry(3, 5'd9, 6'd43, 6'd13);
    setEntry(2, 5'd10, 6'd46, 6'd16);
  endtask

  task automatic loadRobBasic();
    clearRob();
    setEntry(0, 5'd1, 6'd32, 6'd1);
    setEntry(1, 5'd2, 6'd33, 6'd2);
    setEntry(3, 5'd3, 6'd34, 6'd3);
    setEntry(4, 5'd4, 6'd35, 6'd4);
  endtask

  // Presents one report for a single cycle; called at posedge+1 and returns at the next posedge+1.
  task automatic applyStimulus(input logic [3:0] idx, input logic ep, input logic [31:0] pc);
    mp_valid = 1'b1; mp_rob_idx = idx; mp_epoch = ep; mp_target_pc = pc;
    #1;
    checkOutput("stall_in_accept", 32'(stall_alloc), 32'd1);
    @(posedge clk); #1;
    mp_valid = 1'b0;
  endtask

  task automatic waitRedirect(input int exp_lat, input logic [31:0] exp_pc);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (redirect_valid) break;
    end
    checkOutput("redirect_seen", 32'(redirect_valid), 32'd1);
    checkOutput("redirect_latency", 32'(cyc - accept_cyc), 32'(exp_lat));
    checkOutput("redirect_pc", redirect_pc, exp_pc);
  endtask

  task automatic finishRedirect(input logic exp_epoch);
    redirect_ready = 1'b1;
    @(posedge clk); #1;
    redirect_ready = 1'b0;
    checkOutput("idle_after_redirect", 32'(busy), 32'd0);
    checkOutput("redirect_dropped", 32'(redirect_valid), 32'd0);
    checkOutput("epoch_after", 32'(epoch), 32'(exp_epoch));
    checkOutput("queues_drained", 32'(rat_q.size() + fl_q.size() + tail_q.size()), 32'd0);
  endtask

  initial begin
    checks = 0; failures = 0; cyc = 0; accept_cyc = 0;
    rst_n = 1'b0; mp_valid = 1'b0; mp_rob_idx = '0; mp_epoch = 1'b0; mp_target_pc = '0;
    rob_head = '0; rob_tail = '0; redirect_ready = 1'b0;
    clearRob();
    #12;
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_epoch", 32'(epoch), 32'd0);
    checkOutput("reset_stall", 32'(stall_alloc), 32'd0);
    checkOutput("reset_strobes", 32'({rat_wr_valid, fl_push_valid, rob_tail_wr_valid, redirect_valid}), 32'd0);
    checkOutput("reset_redirect_pc", redirect_pc, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic: squash entries 4 and 3 behind branch 2.
    $display("[TB] basic recovery");
    loadRobBasic(); rob_head = 4'd0; rob_tail = 4'd5;
    rat_q.push_back({5'd4, 6'd4}); rat_q.push_back({5'd3, 6'd3});
    fl_q.push_back(6'd35); fl_q.push_back(6'd34); tail_q.push_back(4'd3);
    accept_cyc = cyc;
    applyStimulus(4'd2, 1'b0, 32'h0000_1000);
    checkOutput("walk_first_idx", 32'(walk_rd_idx), 32'd4);
    waitRedirect(5, 32'h0000_1000);
    finishRedirect(1'b1);

    // Branch is the youngest entry: no restores at all.
    $display("[TB] youngest branch");
    tail_q.push_back(4'd5);
    accept_cyc = cyc;
    applyStimulus(4'd4, 1'b1, 32'h0000_2000);
    waitRedirect(3, 32'h0000_2000);
    finishRedirect(1'b0);

    // Index wrap: head 14, branch 15, cursor visits 1 then 0.
    $display("[TB] wrap");
    clearRob();
    setEntry(1, 5'd5, 6'd40, 6'd10);
    setEntry(0, 5'd6, 6'd41, 6'd11);
    rob_head = 4'd14; rob_tail = 4'd2;
    rat_q.push_back({5'd5, 6'd10}); rat_q.push_back({5'd6, 6'd11});
    fl_q.push_back(6'd40); fl_q.push_back(6'd41); tail_q.push_back(4'd0);
    accept_cyc = cyc;
    applyStimulus(4'd15, 1'b0, 32'h0000_3000);
    checkOutput("walk_wrap_idx", 32'(walk_rd_idx), 32'd1);
    waitRedirect(5, 32'h0000_3000);
    finishRedirect(1'b1);

    // Younger in-walk report ignored, older one extends the walk through entry 2.
    $display("[TB] nested reports");
    loadRobLong(); rob_head = 4'd0; rob_tail = 4'd6;
    rat_q.push_back({5'd7, 6'd15}); rat_q.push_back({5'd8, 6'd14});
    rat_q.push_back({5'd9, 6'd13}); rat_q.push_back({5'd10, 6'd16});
    fl_q.push_back(6'd45); fl_q.push_back(6'd44); fl_q.push_back(6'd43); fl_q.push_back(6'd46);
    tail_q.push_back(4'd2);
    accept_cyc = cyc;
    applyStimulus(4'd2, 1'b1, 32'h0000_4000);
    applyStimulus(4'd3, 1'b1, 32'h0000_0BAD);
    applyStimulus(4'd1, 1'b1, 32'h1111_0000);
    waitRedirect(7, 32'h1111_0000);
    finishRedirect(1'b0);

    // Stale reports are dropped; redirect holds while ready is low.
    $display("[TB] stale epoch and redirect backpressure");
    mp_valid = 1'b1; mp_rob_idx = 4'd1; mp_epoch = 1'b1; mp_target_pc = 32'hDEAD_0000;
    #1;
    checkOutput("stale_no_stall", 32'(stall_alloc), 32'd0);
    @(posedge clk); #1;
    mp_valid = 1'b0;
    checkOutput("stale_not_busy", 32'(busy), 32'd0);
    rob_tail = 4'd3;
    tail_q.push_back(4'd3);
    accept_cyc = cyc;
    applyStimulus(4'd2, 1'b0, 32'h0000_5000);
    waitRedirect(3, 32'h0000_5000);
    checkOutput("epoch_toggled", 32'(epoch), 32'd1);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) begin
        mp_valid = 1'b1; mp_rob_idx = 4'd0; mp_epoch = 1'b0; mp_target_pc = 32'hDEAD_1111;
      end
      @(negedge clk);
      checkOutput("redirect_hold_valid", 32'(redirect_valid), 32'd1);
      checkOutput("redirect_hold_pc", redirect_pc, 32'h0000_5000);
    end
    mp_valid = 1'b0;
    finishRedirect(1'b1);

    // Reset in the middle of a walk.
    $display("[TB] reset mid-walk");
    loadRobLong(); rob_tail = 4'd6;
    rat_q.push_back({5'd7, 6'd15}); rat_q.push_back({5'd8, 6'd14});
    fl_q.push_back(6'd45); fl_q.push_back(6'd44);
    accept_cyc = cyc;
    applyStimulus(4'd1, 1'b1, 32'h0000_6000);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_epoch", 32'(epoch), 32'd0);
    checkOutput("rst_strobes", 32'({rat_wr_valid, fl_push_valid, rob_tail_wr_valid, redirect_valid}), 32'd0);
    checkOutput("rst_walk_idx", 32'(walk_rd_idx), 32'd0);
    checkOutput("rst_queues", 32'(rat_q.size() + fl_q.size()), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] recovery after reset");
    loadRobBasic(); rob_head = 4'd0; rob_tail = 4'd5;
    rat_q.push_back({5'd4, 6'd4}); rat_q.push_back({5'd3, 6'd3});
    fl_q.push_back(6'd35); fl_q.push_back(6'd34); tail_q.push_back(4'd3);
    accept_cyc = cyc;
    applyStimulus(4'd2, 1'b0, 32'h0000_7000);
    waitRedirect(5, 32'h0000_7000);
    finishRedirect(1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
